// File: rtl/bounce_painter.sv
// Bouncing square painter: configurable square over a background colour,
// moved once per frame and reflected off the screen edges.
module bounce_painter #(
    parameter int CORDW  = 10,
    parameter int COLRW  = 4,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int SIZE   = 200,
    parameter int SPEED  = 1,
    parameter int INIT_X = 220,
    parameter int INIT_Y = 140
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [CORDW-1:0]   sx_in,
    input  logic [CORDW-1:0]   sy_in,
    input  logic               de_in,
    input  logic               frame_in,
    input  logic               move_en,
    input  logic [3*COLRW-1:0] fg_colr,
    input  logic [3*COLRW-1:0] bg_colr,
    output logic [CORDW-1:0]   sx_out,
    output logic [CORDW-1:0]   sy_out,
    output logic               de_out,
    output logic [7:0]         r_out,
    output logic [7:0]         g_out,
    output logic [7:0]         b_out
);

    localparam int W = CORDW + 1;

    localparam logic [W-1:0] SIZE_W  = W'(SIZE);
    localparam logic [W-1:0] SPEED_W = W'(SPEED);
    localparam logic [W-1:0] HRES_W  = W'(H_RES);
    localparam logic [W-1:0] VRES_W  = W'(V_RES);
    localparam logic [W-1:0] INITX_W = W'(INIT_X);
    localparam logic [W-1:0] INITY_W = W'(INIT_Y);

    typedef struct packed {
        logic [CORDW-1:0] sx;
        logic [CORDW-1:0] sy;
        logic             de;
        logic             hit;
    } s1_t;

    logic [W-1:0] qx, qy;
    logic         dir_x, dir_y;
    logic [W-1:0] qx_nx, qy_nx;
    logic         dir_x_nx, dir_y_nx;

    logic [W-1:0] sx_w, sy_w;
    logic         hit;
    s1_t          s1;

    logic [3*COLRW-1:0] colr_sel;

    // Bit replication: output bit 7-i takes channel bit (i mod COLRW) from the top.
    function automatic logic [7:0] expand(input logic [COLRW-1:0] c);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[7-i] = c[COLRW-1-(i%COLRW)];
        end
        return expand_ret(e);
    endfunction

    function automatic logic [7:0] expand_ret(input logic [7:0] e);
        return e;
    endfunction

    // One axis step: returns {dir, pos}; dir 0 moves toward the limit.
    function automatic logic [W:0] axis_step(
        input logic [W-1:0] q,
        input logic         dir,
        input logic [W-1:0] lim
    );
        logic [W-1:0] nq;
        logic         nd;
        nq = q;
        nd = dir;
        if (!dir) begin
            if (q + SIZE_W + SPEED_W > lim) begin
                nd = 1'b1;
                nq = q - SPEED_W;
            end else begin
                nq = q + SPEED_W;
            end
        end else begin
            if (q < SPEED_W) begin
                nd = 1'b0;
                nq = q + SPEED_W;
            end else begin
                nq = q - SPEED_W;
            end
        end
        return {nd, nq};
    endfunction

    always_comb begin
        qx_nx    = qx;
        qy_nx    = qy;
        dir_x_nx = dir_x;
        dir_y_nx = dir_y;
        {dir_x_nx, qx_nx} = axis_step(qx, dir_x, HRES_W);
        {dir_y_nx, qy_nx} = axis_step(qy, dir_y, VRES_W);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            qx    <= INITX_W;
            qy    <= INITY_W;
            dir_x <= 1'b0;
            dir_y <= 1'b0;
        end else if (frame_in && move_en) begin
            qx    <= qx_nx;
            qy    <= qy_nx;
            dir_x <= dir_x_nx;
            dir_y <= dir_y_nx;
        end
    end

    assign sx_w = {1'b0, sx_in};
    assign sy_w = {1'b0, sy_in};

    assign hit = (sx_w >= qx) && (sx_w < qx + SIZE_W) &&
                 (sy_w >= qy) && (sy_w < qy + SIZE_W);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1 <= '0;
        end else begin
            s1.sx  <= sx_in;
            s1.sy  <= sy_in;
            s1.de  <= de_in;
            s1.hit <= hit;
        end
    end

    // Blanking forces black regardless of the selected colour.
    always_comb begin
        colr_sel = '0;
        if (s1.de) begin
            colr_sel = s1.hit ? fg_colr : bg_colr;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sx_out <= '0;
            sy_out <= '0;
            de_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else begin
            sx_out <= s1.sx;
            sy_out <= s1.sy;
            de_out <= s1.de;
            r_out  <= expand(colr_sel[3*COLRW-1 -: COLRW]);
            g_out  <= expand(colr_sel[2*COLRW-1 -: COLRW]);
            b_out  <= expand(colr_sel[COLRW-1:0]);
        end
    end

endmodule

// File: tb/tb_bounce_painter.sv
// Bench for bounce_painter: four parameter variants checked every cycle
// against a velocity-based reference model, plus hand-computed pixels.
module tb_bounce_painter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, de, frame, move;
    logic [9:0] sx, sy;
    logic [11:0] fg, bg;
    logic [8:0]  fg3, bg3;

    logic [9:0] sxo [4];
    logic [9:0] syo [4];
    logic       deo [4];
    logic [7:0] ro  [4];
    logic [7:0] go  [4];
    logic [7:0] bo  [4];

    int n_tests = 0;
    int n_fail  = 0;
    logic cmp_en = 1'b0;

    localparam int IX [4] = '{220, 439, 1, 220};
    localparam int IY [4] = '{140, 279, 1, 140};
    localparam int SP [4] = '{1, 1, 2, 1};
    localparam int CW [4] = '{4, 4, 4, 3};

    bounce_painter #(.INIT_X(220), .INIT_Y(140)) u0 (
        .clk_in(clk), .rst_in(rst), .sx_in(sx), .sy_in(sy), .de_in(de),
        .frame_in(frame), .move_en(move), .fg_colr(fg), .bg_colr(bg),
        .sx_out(sxo[0]), .sy_out(syo[0]), .de_out(deo[0]),
        .r_out(ro[0]), .g_out(go[0]), .b_out(bo[0]));

    bounce_painter #(.INIT_X(439), .INIT_Y(279)) u1 (
        .clk_in(clk), .rst_in(rst), .sx_in(sx), .sy_in(sy), .de_in(de),
        .frame_in(frame), .move_en(move), .fg_colr(fg), .bg_colr(bg),
        .sx_out(sxo[1]), .sy_out(syo[1]), .de_out(deo[1]),
        .r_out(ro[1]), .g_out(go[1]), .b_out(bo[1]));

    bounce_painter #(.INIT_X(1), .INIT_Y(1), .SPEED(2)) u2 (
        .clk_in(clk), .rst_in(rst), .sx_in(sx), .sy_in(sy), .de_in(de),
        .frame_in(frame), .move_en(move), .fg_colr(fg), .bg_colr(bg),
        .sx_out(sxo[2]), .sy_out(syo[2]), .de_out(deo[2]),
        .r_out(ro[2]), .g_out(go[2]), .b_out(bo[2]));

    bounce_painter #(.COLRW(3)) u3 (
        .clk_in(clk), .rst_in(rst), .sx_in(sx), .sy_in(sy), .de_in(de),
        .frame_in(frame), .move_en(move), .fg_colr(fg3), .bg_colr(bg3),
        .sx_out(sxo[3]), .sy_out(syo[3]), .de_out(deo[3]),
        .r_out(ro[3]), .g_out(go[3]), .b_out(bo[3]));

    // Reference model: signed velocity per axis, reflected at the walls.
    int          mqx [4];
    int          mqy [4];
    int          mvx [4];
    int          mvy [4];
    logic [9:0]  m1sx [4];
    logic [9:0]  m1sy [4];
    logic        m1de [4];
    logic        m1hit [4];
    logic [44:0] mexp [4];

    function automatic logic [7:0] expand(input int v, input int w);
        logic [7:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            o[7-i] = ((v >> (w - 1 - (i % w))) & 1) != 0;
        end
        return o;
    endfunction

    function automatic logic [23:0] colour(input int k, input logic h,
                                           input logic d);
        int v, w, m;
        w = CW[k];
        m = (1 << w) - 1;
        if (!d) return 24'h0;
        if (k == 3) v = h ? int'(fg3) : int'(bg3);
        else        v = h ? int'(fg)  : int'(bg);
        return {expand((v >> (2 * w)) & m, w),
                expand((v >> w) & m, w),
                expand(v & m, w)};
    endfunction

    function automatic logic inside_sq(input int k);
        return int'(sx) >= mqx[k] && int'(sx) < mqx[k] + 200 &&
               int'(sy) >= mqy[k] && int'(sy) < mqy[k] + 200;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                mqx[k]   <= IX[k];
                mqy[k]   <= IY[k];
                mvx[k]   <= SP[k];
                mvy[k]   <= SP[k];
                m1sx[k]  <= '0;
                m1sy[k]  <= '0;
                m1de[k]  <= 1'b0;
                m1hit[k] <= 1'b0;
                mexp[k]  <= '0;
            end else begin
                m1sx[k]  <= sx;
                m1sy[k]  <= sy;
                m1de[k]  <= de;
                m1hit[k] <= inside_sq(k);
                mexp[k]  <= {m1sx[k], m1sy[k], m1de[k],
                             colour(k, m1hit[k], m1de[k])};
                if (frame && move) begin
                    if (mqx[k] + mvx[k] < 0 ||
                        mqx[k] + mvx[k] + 200 > 640) begin
                        mvx[k] <= -mvx[k];
                        mqx[k] <= mqx[k] - mvx[k];
                    end else begin
                        mqx[k] <= mqx[k] + mvx[k];
                    end
                    if (mqy[k] + mvy[k] < 0 ||
                        mqy[k] + mvy[k] + 200 > 480) begin
                        mvy[k] <= -mvy[k];
                        mqy[k] <= mqy[k] - mvy[k];
                    end else begin
                        mqy[k] <= mqy[k] + mvy[k];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 4; k++) begin
                logic [44:0] act;
                act = {sxo[k], syo[k], deo[k], ro[k], go[k], bo[k]};
                n_tests++;
                if (act !== mexp[k]) begin
                    n_fail++;
                    $display("FAIL model_u%0d t=%0t: got %h want %h",
                             k, $time, act, mexp[k]);
                end
            end
        end
    end

    function automatic logic [23:0] rgb(input int k);
        return {ro[k], go[k], bo[k]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic px(input int x, input int y, input logic d);
        sx    = 10'(x);
        sy    = 10'(y);
        de    = d;
        frame = 1'b0;
        move  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse(input int n, input logic mv);
        de    = 1'b0;
        frame = 1'b1;
        move  = mv;
        repeat (n) @(negedge clk);
        frame = 1'b0;
        move  = 1'b0;
    endtask

    localparam logic [23:0] FGC = 24'hFFFFFF;
    localparam logic [23:0] BGC = 24'h113377;

    initial begin
        rst   = 1'b1;
        de    = 1'b1;
        sx    = 10'd300;
        sy    = 10'd200;
        frame = 1'b0;
        move  = 1'b0;
        fg    = 12'hFFF;
        bg    = 12'h137;
        fg3   = 9'b101_011_001;
        bg3   = 9'b111_000_010;

        @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_rgb_a", rgb(0), 0);
        @(negedge clk);
        chk("rst_rgb_b", rgb(0), 0);
        chk("rst_de", deo[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("flush_1", rgb(0), 0);
        @(negedge clk);
        chk("first_px", rgb(0), FGC);

        px(220, 140, 1'b1); chk("hit_tl", rgb(0), FGC);
        px(420, 140, 1'b1); chk("miss_r", rgb(0), BGC);
        px(219, 140, 1'b1); chk("miss_l", rgb(0), BGC);
        px(300, 200, 1'b0); chk("blank_rgb", rgb(0), 0);
        chk("blank_de", deo[0], 0);

        pulse(10, 1'b0);
        px(220, 140, 1'b1); chk("hold_tl", rgb(0), FGC);
        px(219, 140, 1'b1); chk("hold_l", rgb(0), BGC);
        px(419, 339, 1'b1); chk("hold_br", rgb(0), FGC);

        pulse(1, 1'b1);
        px(639, 479, 1'b1); chk("rb_in", rgb(1), FGC);
        px(220, 140, 1'b1); chk("mv1_old", rgb(0), BGC);
        pulse(1, 1'b1);
        px(639, 479, 1'b1); chk("rb_out", rgb(1), BGC);
        px(638, 478, 1'b1); chk("rb_edge", rgb(1), FGC);

        pulse(3, 1'b1);
        px(225, 145, 1'b1); chk("mv5_tl", rgb(0), FGC);
        px(224, 145, 1'b1); chk("mv5_l", rgb(0), BGC);
        px(425, 344, 1'b1); chk("mv5_r", rgb(0), BGC);

        px(300, 200, 1'b1); chk("c3_fg", rgb(3), 24'hB66D24);
        px(0, 0, 1'b1);     chk("c3_bg", rgb(3), 24'hFF0049);

        rst   = 1'b1;
        frame = 1'b1;
        move  = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        frame = 1'b0;
        move  = 1'b0;
        px(220, 140, 1'b1); chk("rstmv_tl", rgb(0), FGC);
        px(219, 140, 1'b1); chk("rstmv_l", rgb(0), BGC);
        pulse(1, 1'b1);
        px(220, 140, 1'b1); chk("dir_old", rgb(0), BGC);
        px(221, 141, 1'b1); chk("dir_new", rgb(0), FGC);

        pulse(437, 1'b1);
        px(1, 237, 1'b1); chk("lt_q1", rgb(2), FGC);
        px(0, 237, 1'b1); chk("lt_q0", rgb(2), BGC);
        pulse(1, 1'b1);
        px(3, 235, 1'b1); chk("lt_in", rgb(2), FGC);
        px(2, 235, 1'b1); chk("lt_out", rgb(2), BGC);
        px(0, 300, 1'b1); chk("lt_x0", rgb(2), BGC);
        px(3, 434, 1'b1); chk("lt_bot", rgb(2), FGC);
        px(3, 435, 1'b1); chk("lt_below", rgb(2), BGC);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
